// File: rtl/ev22_regfile_2r1w_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ev22_regfile_2r1w_if : bus bundle for the EV22 2-read/1-write regfile    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface ev22_regfile_2r1w_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
);
   logic [DATA_W-1:0] pi0;
   logic [DATA_W-1:0] pi1;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] sel_a;
   logic [ADDR_W-1:0] sel_b;
   logic [DATA_W-1:0] data_a;
   logic [DATA_W-1:0] data_b;
   logic              rd_valid;
   logic [DATA_W-1:0] wreg;
   logic              clr_req;
   logic              busy;
   logic              err_clr;
   logic              addr_err;

   modport master (
      output pi0, pi1, wr_en, wr_addr, wr_data, rd_en, sel_a, sel_b, clr_req, err_clr,
      input  data_a, data_b, rd_valid, wreg, busy, addr_err
   );

   modport slave (
      input  pi0, pi1, wr_en, wr_addr, wr_data, rd_en, sel_a, sel_b, clr_req, err_clr,
      output data_a, data_b, rd_valid, wreg, busy, addr_err
   );
endinterface
`default_nettype wire

// File: rtl/ev22_regfile_2r1w.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ev22_regfile_2r1w : EV22 register file, 2 registered reads, 1 write,     |
// | sequential clear engine, sticky address-error flag.                      |
// | Optional: REGFILE_BYPASS_EN enables same-edge write-through forwarding.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module ev22_regfile_2r1w #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 6,
   parameter int NUM_GPR   = 28,
   parameter int PI0_ADDR  = 28,
   parameter int PI1_ADDR  = 29,
   parameter int R32_ADDR  = 32,
   parameter int R33_ADDR  = 33,
   parameter int WREG_ADDR = 34
) (
   input  logic                clk,
   input  logic                reset,
   ev22_regfile_2r1w_if.slave  bus
);

   localparam int CNT_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NUM_GPR - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   logic [DATA_W-1:0] r_gpr [NUM_GPR];
   logic [DATA_W-1:0] r_r32;
   logic [DATA_W-1:0] r_r33;
   logic [DATA_W-1:0] r_wreg;
   logic [DATA_W-1:0] r_data_a;
   logic [DATA_W-1:0] r_data_b;
   logic              r_rd_valid;
   logic              r_addr_err;
   logic              r_busy;
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_wr_legal;
   logic              w_wr_do;
   logic              w_wr_err;
   logic              w_err_set;
   logic [DATA_W-1:0] w_val_a;
   logic [DATA_W-1:0] w_val_b;
   logic              w_ok_a;
   logic              w_ok_b;

   assign w_wr_legal = (bus.wr_addr < ADDR_W'(NUM_GPR))       ||
                       (bus.wr_addr == ADDR_W'(R32_ADDR))     ||
                       (bus.wr_addr == ADDR_W'(R33_ADDR))     ||
                       (bus.wr_addr == ADDR_W'(WREG_ADDR));
   // Writes during a clear are swallowed without flagging an error.
   assign w_wr_do   = bus.wr_en & ~r_busy &  w_wr_legal;
   assign w_wr_err  = bus.wr_en & ~r_busy & ~w_wr_legal;
   assign w_err_set = w_wr_err | (bus.rd_en & (~w_ok_a | ~w_ok_b));

   always_comb begin
      w_val_a = '0;
      w_val_b = '0;
      w_ok_a  = 1'b0;
      w_ok_b  = 1'b0;
      for (int i = 0; i < NUM_GPR; i++) begin
         if (bus.sel_a == ADDR_W'(i)) begin
            w_val_a = r_gpr[i];
            w_ok_a  = 1'b1;
         end
         if (bus.sel_b == ADDR_W'(i)) begin
            w_val_b = r_gpr[i];
            w_ok_b  = 1'b1;
         end
      end
      if (bus.sel_a == ADDR_W'(PI0_ADDR)) begin w_val_a = bus.pi0; w_ok_a = 1'b1; end
      if (bus.sel_a == ADDR_W'(PI1_ADDR)) begin w_val_a = bus.pi1; w_ok_a = 1'b1; end
      if (bus.sel_a == ADDR_W'(R32_ADDR)) begin w_val_a = r_r32;   w_ok_a = 1'b1; end
      if (bus.sel_a == ADDR_W'(R33_ADDR)) begin w_val_a = r_r33;   w_ok_a = 1'b1; end
      if (bus.sel_b == ADDR_W'(PI0_ADDR)) begin w_val_b = bus.pi0; w_ok_b = 1'b1; end
      if (bus.sel_b == ADDR_W'(PI1_ADDR)) begin w_val_b = bus.pi1; w_ok_b = 1'b1; end
      if (bus.sel_b == ADDR_W'(R32_ADDR)) begin w_val_b = r_r32;   w_ok_b = 1'b1; end
      if (bus.sel_b == ADDR_W'(R33_ADDR)) begin w_val_b = r_r33;   w_ok_b = 1'b1; end
      if (bus.sel_b == ADDR_W'(WREG_ADDR)) begin w_val_b = r_wreg; w_ok_b = 1'b1; end
`ifdef REGFILE_BYPASS_EN
      if (w_wr_do && w_ok_a && (bus.wr_addr == bus.sel_a)) w_val_a = bus.wr_data;
      if (w_wr_do && w_ok_b && (bus.wr_addr == bus.sel_b)) w_val_b = bus.wr_data;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.clr_req) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (r_cnt == c_last_cnt) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
         r_r32  <= '0;
         r_r33  <= '0;
         r_wreg <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++) begin
            if (w_wr_do && (bus.wr_addr == ADDR_W'(i))) r_gpr[i] <= bus.wr_data;
            if ((r_state == ST_CLEAR) && (r_cnt == CNT_W'(i))) r_gpr[i] <= '0;
         end
         if (w_wr_do && (bus.wr_addr == ADDR_W'(R32_ADDR)))  r_r32  <= bus.wr_data;
         if (w_wr_do && (bus.wr_addr == ADDR_W'(R33_ADDR)))  r_r33  <= bus.wr_data;
         if (w_wr_do && (bus.wr_addr == ADDR_W'(WREG_ADDR))) r_wreg <= bus.wr_data;
         if ((r_state == ST_CLEAR) && (r_cnt == c_last_cnt)) begin
            r_r32  <= '0;
            r_r33  <= '0;
            r_wreg <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data_a   <= '0;
         r_data_b   <= '0;
         r_rd_valid <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         if (bus.rd_en) begin
            r_data_a <= w_val_a;
            r_data_b <= w_val_b;
         end
         r_rd_valid <= bus.rd_en;
         // A new error in the same cycle as err_clr keeps the flag set.
         r_addr_err <= w_err_set | (r_addr_err & ~bus.err_clr);
      end
   end

   assign bus.data_a   = r_data_a;
   assign bus.data_b   = r_data_b;
   assign bus.rd_valid = r_rd_valid;
   assign bus.wreg     = r_wreg;
   assign bus.busy     = r_busy;
   assign bus.addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_ev22_regfile_2r1w.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ev22_regfile_2r1w : scoreboard bench for ev22_regfile_2r1w            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_ev22_regfile_2r1w;
   localparam int NGPR = 28;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ev22_regfile_2r1w_if #(.DATA_W(16), .ADDR_W(6)) bus ();

   ev22_regfile_2r1w dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] sb_q [$];
   logic [15:0] m_reg [64];
   logic        m_busy = 1'b0;
   int          m_cnt  = 0;
   logic        m_err  = 1'b0;
   logic [15:0] m_last_a = '0;
   logic [15:0] m_last_b = '0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic wr_legal(input logic [5:0] a);
      return (a < 6'(NGPR)) || (a == 6'd32) || (a == 6'd33) || (a == 6'd34);
   endfunction

   function automatic logic [15:0] m_read(input logic [5:0] s, input bit port_b, output logic ok);
      ok = 1'b1;
      if (s < 6'(NGPR) || s == 6'd32 || s == 6'd33) return m_reg[s];
      if (s == 6'd28) return bus.pi0;
      if (s == 6'd29) return bus.pi1;
      if (port_b && s == 6'd34) return m_reg[s];
      ok = 1'b0;
      return 16'h0000;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_reg[i] = '0;
      m_busy = 1'b0; m_cnt = 0; m_err = 1'b0;
      m_last_a = '0; m_last_b = '0;
   endtask

   // Drives one clock with whatever strobes are currently set, then clears them.
   task automatic step();
      logic [15:0] ea, eb;
      logic oka, okb, werr, wdo;
      oka = 1'b1; okb = 1'b1; ea = '0; eb = '0;
      wdo  = bus.wr_en && !m_busy && wr_legal(bus.wr_addr);
      werr = bus.wr_en && !m_busy && !wr_legal(bus.wr_addr);
      if (bus.rd_en) begin
         ea = m_read(bus.sel_a, 1'b0, oka);
         eb = m_read(bus.sel_b, 1'b1, okb);
`ifdef REGFILE_BYPASS_EN
         if (wdo && oka && bus.wr_addr == bus.sel_a) ea = bus.wr_data;
         if (wdo && okb && bus.wr_addr == bus.sel_b) eb = bus.wr_data;
`endif
         sb_q.push_back({ea, eb});
      end
      @(posedge clk);
      if (wdo) m_reg[bus.wr_addr] = bus.wr_data;
      if (m_busy) begin
         m_reg[m_cnt] = '0;
         if (m_cnt == NGPR - 1) begin
            m_reg[32] = '0; m_reg[33] = '0; m_reg[34] = '0;
            m_busy = 1'b0;
         end else m_cnt++;
      end else if (bus.clr_req) begin
         m_busy = 1'b1; m_cnt = 0;
      end
      m_err = werr | (bus.rd_en & (~oka | ~okb)) | (m_err & ~bus.err_clr);
      #1;
      check_value("busy", 32'(bus.busy), 32'(m_busy));
      check_value("addr_err", 32'(bus.addr_err), 32'(m_err));
      check_value("wreg", 32'(bus.wreg), 32'(m_reg[34]));
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_req = 1'b0; bus.err_clr = 1'b0;
   endtask

   task automatic do_wr(input logic [5:0] a, input logic [15:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      step();
   endtask

   task automatic do_rd(input logic [5:0] sa, input logic [5:0] sb);
      bus.rd_en = 1'b1; bus.sel_a = sa; bus.sel_b = sb;
      step();
   endtask

   task automatic fill_all();
      for (int i = 0; i < NGPR; i++) do_wr(6'(i), 16'h1000 + 16'(i) + 16'h1);
      do_wr(6'd32, 16'hC032);
      do_wr(6'd33, 16'hC033);
      do_wr(6'd34, 16'hC034);
   endtask

   task automatic read_all();
      for (int i = 0; i < NGPR; i++) do_rd(6'(i), 6'(32 + (i % 3)));
      do_rd(6'd32, 6'd33);
   endtask

   // Output monitor: pops the scoreboard on rd_valid, otherwise checks hold.
   always begin
      logic [31:0] e;
      @(posedge clk);
      #2;
      if (bus.rd_valid) begin
         if (sb_q.size() == 0) check_value("rd_valid_spurious", 32'd1, 32'd0);
         else begin
            e = sb_q.pop_front();
            check_value("data_a", 32'(bus.data_a), 32'(e[31:16]));
            check_value("data_b", 32'(bus.data_b), 32'(e[15:0]));
            m_last_a = e[31:16];
            m_last_b = e[15:0];
         end
      end else if (!reset) begin
         check_value("hold_a", 32'(bus.data_a), 32'(m_last_a));
         check_value("hold_b", 32'(bus.data_b), 32'(m_last_b));
      end
   end

   initial begin
      int n;
      bus.pi0 = '0; bus.pi1 = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.rd_en = 1'b0; bus.sel_a = '0; bus.sel_b = '0; bus.clr_req = 1'b0; bus.err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_value("rst_data_a", 32'(bus.data_a), 32'd0);
      check_value("rst_data_b", 32'(bus.data_b), 32'd0);
      check_value("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check_value("rst_busy", 32'(bus.busy), 32'd0);
      check_value("rst_addr_err", 32'(bus.addr_err), 32'd0);
      check_value("rst_wreg", 32'(bus.wreg), 32'd0);

      do_rd(6'd5, 6'd34);
      step();
      check_value("rd_valid_pulse", 32'(bus.rd_valid), 32'd0);

      do_wr(6'd7, 16'hBEEF);
      do_wr(6'd34, 16'h1234);
      check_value("wreg_direct", 32'(bus.wreg), 32'h1234);
      do_rd(6'd7, 6'd34);

      do_wr(6'd3, 16'h0001);
      bus.wr_en = 1'b1; bus.wr_addr = 6'd3; bus.wr_data = 16'hA5A5;
      bus.rd_en = 1'b1; bus.sel_a = 6'd3; bus.sel_b = 6'd34;
      step();
      bus.wr_en = 1'b1; bus.wr_addr = 6'd34; bus.wr_data = 16'h5A5A;
      bus.rd_en = 1'b1; bus.sel_a = 6'd7; bus.sel_b = 6'd34;
      step();
      do_rd(6'd3, 6'd34);

      bus.pi0 = 16'h00FF; bus.pi1 = 16'h7E57;
      do_rd(6'd28, 6'd29);
      do_wr(6'd28, 16'hDEAD);
      do_rd(6'd34, 6'd31);
      bus.err_clr = 1'b1; step();
      bus.err_clr = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 6'd30; bus.wr_data = 16'h1111;
      step();
      bus.err_clr = 1'b1; step();
      do_rd(6'd63, 6'd35);
      bus.err_clr = 1'b1; step();

      fill_all();
      read_all();
      bus.clr_req = 1'b1; step();
      n = 0;
      while (bus.busy && n < 40) begin
         if (n == 0) begin
            bus.wr_en = 1'b1; bus.wr_addr = 6'd20; bus.wr_data = 16'hFFFF;
            bus.rd_en = 1'b1; bus.sel_a = 6'd20; bus.sel_b = 6'd34;
            bus.clr_req = 1'b1;
         end
         step();
         n++;
      end
      check_value("busy_len", 32'(n), 32'(NGPR));
      read_all();

      fill_all();
      bus.clr_req = 1'b1; step();
      repeat (10) step();
      reset = 1'b1;
      #1;
      model_reset();
      check_value("midclr_busy", 32'(bus.busy), 32'd0);
      check_value("midclr_wreg", 32'(bus.wreg), 32'd0);
      check_value("midclr_data_a", 32'(bus.data_a), 32'd0);
      #2 reset = 1'b0;
      read_all();
      fill_all();
      bus.clr_req = 1'b1; step();
      n = 0;
      while (bus.busy && n < 40) begin step(); n++; end
      check_value("busy_len_restart", 32'(n), 32'(NGPR));
      read_all();

      for (int k = 0; k < 80; k++) begin
         bus.pi0 = 16'($urandom); bus.pi1 = 16'($urandom);
         bus.wr_en = ($urandom_range(0, 1) == 1);
         bus.wr_addr = 6'($urandom_range(0, 36)); bus.wr_data = 16'($urandom);
         bus.rd_en = ($urandom_range(0, 2) != 0);
         bus.sel_a = ($urandom_range(0, 1) == 1) ? bus.wr_addr : 6'($urandom_range(0, 36));
         bus.sel_b = ($urandom_range(0, 1) == 1) ? bus.wr_addr : 6'($urandom_range(0, 36));
         bus.err_clr = ($urandom_range(0, 7) == 0);
         bus.clr_req = ($urandom_range(0, 39) == 0);
         step();
      end
      repeat (2) step();
      check_value("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ev22_regfile_2r1w.md
Name: ev22_regfile_2r1w

Overview:
- Parametrised, clocked register file for the EV22 datapath: general-purpose registers, two special registers (r32/r33), the working register (WREG) and two read-only port-input windows (PI0/PI1).
- Provides two registered read ports (A, B) and one write port.
- Adds a sequential clear engine and a sticky address-error flag.
- Replaces the combinational operand-select block between register storage and the ALU.

Parameters:
DATA_W, 16, register/data width in bits
ADDR_W, 6, select/address width
NUM_GPR, 28, general-purpose registers at addresses 0..NUM_GPR-1 (must be 2..PI0_ADDR)
PI0_ADDR, 28, address of read-only port input 0
PI1_ADDR, 29, address of read-only port input 1
R32_ADDR, 32, address of special register r32
R33_ADDR, 33, address of special register r33
WREG_ADDR, 34, address of working register (port B and write only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pi0  in  DATA_W  external port input 0, readable at PI0_ADDR
pi1  in  DATA_W  external port input 1, readable at PI1_ADDR
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  1  read strobe for both ports
sel_a  in  ADDR_W  port A select
sel_b  in  ADDR_W  port B select
data_a  out  DATA_W  registered port A data
data_b  out  DATA_W  registered port B data
rd_valid  out  1  one-cycle pulse: data_a/data_b updated
wreg  out  DATA_W  direct (unregistered) view of WREG
clr_req  in  1  start clear sequence
busy  out  1  clear sequence in progress
err_clr  in  1  clear sticky error flag
addr_err  out  1  sticky illegal-access flag

Behaviour:
- Reset (async, active-high): all storage, data_a, data_b, and wreg = 0; rd_valid = 0; busy = 0; addr_err = 0; FSM = IDLE; clear counter = 0.
- Read path:
  - rd_en sampled at clk edge.
  - Next cycle: data_a/data_b hold the selected values and rd_valid = 1 for exactly one cycle.
  - Outputs hold their value while rd_en = 0.
- Port A legal addresses: 0..NUM_GPR-1, PI0, PI1, R32, R33. WREG is illegal on port A.
- Port B legal addresses: port A set plus WREG_ADDR.
- Illegal select on a read: that port returns 0 and addr_err sets. Unused PI/GPR gaps are also illegal.
- PI0/PI1 reads sample pi0/pi1 at the rd_en edge. There is no extra synchroniser; the source is synchronous.
- Write path:
  - wr_en at edge writes wr_data to any GPR, R32, R33 or WREG.
  - A write to PI0, PI1 or an unmapped address is dropped and sets addr_err.
- Same-cycle write and read of one address: see REGFILE_BYPASS_EN.
- addr_err is sticky and cleared by err_clr. If set and clear fire in the same cycle, set wins.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req; counter = 0; busy = 1 from the next cycle.
  - In CLEAR, each cycle zeroes GPR[counter] and increments counter.
  - At counter = NUM_GPR-1, that cycle also zeroes R32, R33 and WREG, then -> IDLE with busy = 0.
  - Sequence length is NUM_GPR cycles.
  - clr_req while busy is ignored.
  - wr_en while busy is dropped silently (no addr_err). Reads while busy are allowed and return current contents.
- Reset mid-CLEAR: immediate return to IDLE, all storage 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read at the same edge as a legal write to the same address returns wr_data on that port (write-through forwarding). This applies to both ports, and to WREG on port B.
- Not defined: the read returns the pre-write value, and the new value is visible from the following read.
- Forwarding never applies while busy, or to dropped writes.

Test Plan:
- Reset, then rd_en with sel_a=5, sel_b=34 -> next cycle data_a=0, data_b=0, rd_valid=1 for one cycle, addr_err=0.
- Write 0xBEEF to 7 and 0x1234 to 34; then rd_en with sel_a=7, sel_b=34 -> data_a=0xBEEF, data_b=0x1234; wreg=0x1234 right after the write edge.
- Same-edge write 0xA5A5 to 3 plus rd_en with sel_a=3 (old value 0x0001) -> data_a=0xA5A5 with REGFILE_BYPASS_EN, 0x0001 without it.
- pi0=0x00FF, rd_en with sel_a=28 -> data_a=0x00FF; write to 28 -> dropped, addr_err=1; sel_a=34 -> data_a=0, addr_err stays 1; err_clr -> addr_err=0.
- Fill all registers with nonzero data, pulse clr_req -> busy high for 28 cycles; a write during busy is ignored; afterwards all reads return 0.
- Assert reset at clear cycle 10 -> busy=0 immediately; all registers read 0; a later clr_req restarts from counter 0.
